alu_issue: RTL

// - Issue/drive side of the ALU interface (op1, op2, alu_sel -> res). Accepts one RV32I ALU instruction per

---
 rtl/alu_issue_pkg.sv | 28 ++
 rtl/alu_issue_if.sv | 25 ++
 rtl/alu_issue_dec.sv | 62 ++++++
 rtl/alu_issue.sv | 132 +++++++++++++
 4 files changed

// File: rtl/alu_issue_pkg.sv
// Shared encodings for the ALU issue slice: ALU select codes, RV32I opcode and
// funct fields recognised by the decoder, and the issue FSM state codes.
package alu_issue_pkg;

    typedef enum logic [1:0] {
        ALU_ADD = 2'b00,
        ALU_SUB = 2'b01,
        ALU_OR  = 2'b10,
        ALU_AND = 2'b11
    } alu_sel_e;

    localparam logic [6:0] OPC_OP    = 7'b0110011;
    localparam logic [6:0] OPC_OPIMM = 7'b0010011;

    localparam logic [2:0] F3_ADD = 3'b000;
    localparam logic [2:0] F3_OR  = 3'b110;
    localparam logic [2:0] F3_AND = 3'b111;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_SUB  = 7'b0100000;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_WB   = 2'd2
    } state_e;

endpackage

// File: rtl/alu_issue_if.sv
// Instruction-in and writeback-out handshake channels of the ALU issue block.
// slave: the issue block itself; master: fetch side plus writeback consumer.
interface alu_issue_if #(
    parameter int unsigned XLEN = 32
) ();

    logic            instr_valid;
    logic            instr_ready;
    logic [31:0]     instr;
    logic            wb_valid;
    logic            wb_ready;
    logic [4:0]      wb_rd;
    logic [XLEN-1:0] wb_data;

    modport master (
        output instr_valid, instr, wb_ready,
        input  instr_ready, wb_valid, wb_rd, wb_data
    );

    modport slave (
        input  instr_valid, instr, wb_ready,
        output instr_ready, wb_valid, wb_rd, wb_data
    );

endinterface

// File: rtl/alu_issue_dec.sv
// Combinational RV32I ALU-subset decoder: ADD/SUB/OR/AND and ADDI/ORI/ANDI.
// Anything else reports legal=0.
module alu_issue_dec
    import alu_issue_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic [31:0]     instr,
    output logic            legal,
    output alu_sel_e        alu_sel,
    output logic            use_imm,
    output logic [XLEN-1:0] imm,
    output logic [4:0]      rd,
    output logic [4:0]      rs1,
    output logic [4:0]      rs2
);

    logic [6:0] opcode;
    logic [6:0] funct7;
    logic [2:0] funct3;

    assign opcode = instr[6:0];
    assign funct3 = instr[14:12];
    assign funct7 = instr[31:25];
    assign rd     = instr[11:7];
    assign rs1    = instr[19:15];
    assign rs2    = instr[24:20];
    assign imm    = {{(XLEN-12){instr[31]}}, instr[31:20]};

    // Classify the instruction and pick the ALU operation.
    always_comb begin
        legal   = 1'b0;
        alu_sel = ALU_ADD;
        use_imm = 1'b0;
        case (opcode)
            OPC_OP: begin
                if (funct7 == F7_BASE) begin
                    case (funct3)
                        F3_ADD:  begin legal = 1'b1; alu_sel = ALU_ADD; end
                        F3_OR:   begin legal = 1'b1; alu_sel = ALU_OR;  end
                        F3_AND:  begin legal = 1'b1; alu_sel = ALU_AND; end
                        default: ;
                    endcase
                end else if (funct7 == F7_SUB && funct3 == F3_ADD) begin
                    legal   = 1'b1;
                    alu_sel = ALU_SUB;
                end
            end
            OPC_OPIMM: begin
                use_imm = 1'b1;
                case (funct3)
                    F3_ADD:  begin legal = 1'b1; alu_sel = ALU_ADD; end
                    F3_OR:   begin legal = 1'b1; alu_sel = ALU_OR;  end
                    F3_AND:  begin legal = 1'b1; alu_sel = ALU_AND; end
                    default: ;
                endcase
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/alu_issue.sv
// ALU issue stage: accepts one ALU instruction, reads the register file,
// drives op1/op2/alu_sel for ALU_WAIT cycles, captures res and offers it on
// the writeback channel. Results for rd=x0 are dropped without a writeback.
// Optional: define ALU_ISSUE_BYPASS_EN to forward the last written {rd,data}
// to the operand reads, for register files that write late.
module alu_issue
    import alu_issue_pkg::*;
#(
    parameter int unsigned XLEN     = 32,
    parameter int unsigned ALU_WAIT = 2
) (
    input  logic            clk,
    input  logic            rst,
    alu_issue_if.slave      bus,
    output logic [4:0]      rs1_addr,
    output logic [4:0]      rs2_addr,
    input  logic [XLEN-1:0] rs1_data,
    input  logic [XLEN-1:0] rs2_data,
    output logic [XLEN-1:0] op1,
    output logic [XLEN-1:0] op2,
    output logic [1:0]      alu_sel,
    input  logic [XLEN-1:0] res,
    output logic            illegal
);

    localparam logic [3:0] WAIT_INIT = 4'(ALU_WAIT - 1);

    state_e          state;
    logic [3:0]      count;

    logic            dec_legal;
    alu_sel_e        dec_sel;
    logic            dec_use_imm;
    logic [XLEN-1:0] dec_imm;
    logic [4:0]      dec_rd;
    logic [XLEN-1:0] src1;
    logic [XLEN-1:0] src2;

    alu_issue_dec #(.XLEN(XLEN)) u_dec (
        .instr   (bus.instr),
        .legal   (dec_legal),
        .alu_sel (dec_sel),
        .use_imm (dec_use_imm),
        .imm     (dec_imm),
        .rd      (dec_rd),
        .rs1     (rs1_addr),
        .rs2     (rs2_addr)
    );

    assign bus.instr_ready = (state == ST_IDLE);

`ifdef ALU_ISSUE_BYPASS_EN
    logic [4:0]      byp_rd;
    logic [XLEN-1:0] byp_data;

    // Remember the most recent completed writeback.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            byp_rd   <= '0;
            byp_data <= '0;
        end else if (bus.wb_valid && bus.wb_ready) begin
            byp_rd   <= bus.wb_rd;
            byp_data <= bus.wb_data;
        end
    end

    // Prefer the remembered result over a register file that may not have it yet.
    always_comb begin
        src1 = rs1_data;
        src2 = rs2_data;
        if (byp_rd != '0 && rs1_addr == byp_rd) src1 = byp_data;
        if (byp_rd != '0 && rs2_addr == byp_rd) src2 = byp_data;
    end
`else
    assign src1 = rs1_data;
    assign src2 = rs2_data;
`endif

    // Issue FSM: accept/decode in IDLE, hold operands in EXEC, hand off in WB.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= ST_IDLE;
            count        <= '0;
            op1          <= '0;
            op2          <= '0;
            alu_sel      <= ALU_ADD;
            bus.wb_rd    <= '0;
            bus.wb_data  <= '0;
            bus.wb_valid <= 1'b0;
            illegal      <= 1'b0;
        end else begin
            illegal <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (bus.instr_valid) begin
                        if (dec_legal) begin
                            op1       <= src1;
                            op2       <= dec_use_imm ? dec_imm : src2;
                            alu_sel   <= dec_sel;
                            bus.wb_rd <= dec_rd;
                            count     <= WAIT_INIT;
                            state     <= ST_EXEC;
                        end else begin
                            illegal <= 1'b1;
                        end
                    end
                end
                ST_EXEC: begin
                    if (count == '0) begin
                        bus.wb_data <= res;
                        if (bus.wb_rd != '0) begin
                            bus.wb_valid <= 1'b1;
                            state        <= ST_WB;
                        end else begin
                            state <= ST_IDLE;
                        end
                    end else begin
                        count <= count - 4'd1;
                    end
                end
                ST_WB: begin
                    if (bus.wb_ready) begin
                        bus.wb_valid <= 1'b0;
                        state        <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
